// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the unpipelined MIPS core, directly downstream of
// execute. The ALU result is the byte address and the forwarded rt operand is
// the store data. Each load or store runs one req/ack transaction on the data
// bus. The core is stalled until that transaction completes. The stage then
// produces the write-back value: extracted load data, or the ALU result
// passed through unchanged.
//
// FSM: IDLE -> BUSY -> DONE -> IDLE
//   IDLE : a legal access stalls the core combinationally and launches the
//          request on the next edge. A misaligned access only flags
//          o_alignErr; no bus cycle is started and any store is dropped.
//   BUSY : bus outputs are held stable until i_bus_ack arrives. If no ack
//          arrives within TIMEOUT cycles, the request is aborted, o_busErr
//          pulses and the load data becomes zero.
//   DONE : the stall is released, so the PC advances on this edge.
//          o_wbData carries the result.
//
// Parameters
//   TIMEOUT : maximum number of BUSY cycles without an ack (1 .. 2^CNT_W-1)
//   CNT_W   : width of the timeout counter
//
// Ports
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   i_addr, i_wdata   byte address and store data from execute
//   i_memRead/Write   load / store request (read wins when both are set)
//   i_memToReg        select load data (1) or i_addr (0) for write-back
//   i_size            00 byte, 01 half, 1x word
//   i_unsigned        zero-extend loads when set, sign-extend otherwise
//   o_wbData          write-back value
//   o_stall           hold the PC and upstream state this cycle
//   o_alignErr        misaligned access (combinational, IDLE only)
//   o_busErr          one-cycle pulse after a bus timeout
//   o_bus_*           registered bus request, write enable, word address,
//                     byte enables and lane-replicated store data
//   i_bus_ack         transaction complete; i_bus_rdata is valid in this cycle
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic        i_memToReg,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_wbData,
    output logic        o_stall,
    output logic        o_alignErr,
    output logic        o_busErr,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // A half access needs an even address. A word access needs addr[1:0] == 0.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

    // Little-endian lane enables: lane n covers data bits 8n+7:8n.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = 4'b0011 << {lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is copied to every lane, so the slave only needs to honour
    // the byte enables.
    function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{data[7:0]}};
            2'b01:   r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    // Select the addressed lane(s) and then sign- or zero-extend them.
    function automatic logic [31:0] extract_load(input logic [1:0]  size,
                                                 input logic [1:0]  lo,
                                                 input logic        uns,
                                                 input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = data[7:0];
            2'b01:   b = data[15:8];
            2'b10:   b = data[23:16];
            default: b = data[31:24];
        endcase
        h = lo[1] ? data[31:16] : data[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    state_t             state_r,  state_nxt_s;
    logic [CNT_W-1:0]   cnt_r,    cnt_nxt_s;
    logic [31:0]        rdata_r,  rdata_nxt_s;
    logic [1:0]         lo_r,     lo_nxt_s;
    logic [1:0]         size_r,   size_nxt_s;
    logic               uns_r,    uns_nxt_s;
    logic               req_nxt_s;
    logic               we_nxt_s;
    logic [31:0]        addr_nxt_s;
    logic [3:0]         be_nxt_s;
    logic [31:0]        wdata_nxt_s;
    logic               bus_err_nxt_s;

    logic               mem_op_s;
    logic               aligned_s;
    logic               access_s;
    logic               stall_s;
    logic               align_err_s;
    logic [31:0]        wb_data_s;

    assign mem_op_s  = i_memRead | i_memWrite;
    assign aligned_s = is_aligned(i_size, i_addr[1:0]);
    assign access_s  = mem_op_s & aligned_s;

    // Next-state and output decode for the transaction FSM
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        rdata_nxt_s   = rdata_r;
        lo_nxt_s      = lo_r;
        size_nxt_s    = size_r;
        uns_nxt_s     = uns_r;
        req_nxt_s     = o_bus_req;
        we_nxt_s      = o_bus_we;
        addr_nxt_s    = o_bus_addr;
        be_nxt_s      = o_bus_be;
        wdata_nxt_s   = o_bus_wdata;
        bus_err_nxt_s = 1'b0;
        stall_s       = 1'b0;
        align_err_s   = 1'b0;
        wb_data_s     = i_addr;

        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    stall_s     = 1'b1;
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = '0;
                    req_nxt_s   = 1'b1;
                    // A load takes priority when read and write are both set.
                    we_nxt_s    = i_memWrite & ~i_memRead;
                    addr_nxt_s  = {i_addr[31:2], 2'b00};
                    be_nxt_s    = byte_enables(i_size, i_addr[1:0]);
                    wdata_nxt_s = replicate_store(i_size, i_wdata);
                    lo_nxt_s    = i_addr[1:0];
                    size_nxt_s  = i_size;
                    uns_nxt_s   = i_unsigned;
                end else if (mem_op_s) begin
                    // Misaligned: flag it, launch nothing, write back zero.
                    align_err_s = 1'b1;
                    wb_data_s   = 32'd0;
                end else begin
                    wb_data_s   = i_addr;
                end
            end

            ST_BUSY: begin
                stall_s = 1'b1;
                if (i_bus_ack) begin
                    // An ack in the final timeout cycle still counts as success.
                    rdata_nxt_s = i_bus_rdata;
                    req_nxt_s   = 1'b0;
                    we_nxt_s    = 1'b0;
                    state_nxt_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    rdata_nxt_s   = 32'd0;
                    req_nxt_s     = 1'b0;
                    we_nxt_s      = 1'b0;
                    bus_err_nxt_s = 1'b1;
                    state_nxt_s   = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // Return to IDLE without starting a new request. This ensures
                // the same instruction is not replayed while the PC advances.
                state_nxt_s = ST_IDLE;
                if (i_memToReg) begin
                    wb_data_s = extract_load(size_r, lo_r, uns_r, rdata_r);
                end else begin
                    wb_data_s = i_addr;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                req_nxt_s   = 1'b0;
                we_nxt_s    = 1'b0;
            end
        endcase
    end

    assign o_wbData   = wb_data_s;
    assign o_stall    = stall_s;
    assign o_alignErr = align_err_s;

    // FSM state, bookkeeping and registered bus outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            rdata_r     <= 32'd0;
            lo_r        <= 2'b00;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= 32'd0;
            o_bus_be    <= 4'b0000;
            o_bus_wdata <= 32'd0;
            o_busErr    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            rdata_r     <= rdata_nxt_s;
            lo_r        <= lo_nxt_s;
            size_r      <= size_nxt_s;
            uns_r       <= uns_nxt_s;
            o_bus_req   <= req_nxt_s;
            o_bus_we    <= we_nxt_s;
            o_bus_addr  <= addr_nxt_s;
            o_bus_be    <= be_nxt_s;
            o_bus_wdata <= wdata_nxt_s;
            o_busErr    <= bus_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed bench for mem_access_stage. Each load or store pushes its expected
// write-back value to a queue when the access is driven. The value is popped
// and compared when the stage reaches DONE. Inputs are driven on the falling
// edge, and outputs are sampled 1 time unit later or on the next falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_memRead;
    logic        i_memWrite;
    logic        i_memToReg;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] o_wbData;
    logic        o_stall;
    logic        o_alignErr;
    logic        o_busErr;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] sb_q[$];

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_memRead   (i_memRead),
        .i_memWrite  (i_memWrite),
        .i_memToReg  (i_memToReg),
        .i_size      (i_size),
        .i_unsigned  (i_unsigned),
        .o_wbData    (o_wbData),
        .o_stall     (o_stall),
        .o_alignErr  (o_alignErr),
        .o_busErr    (o_busErr),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_be    (o_bus_be),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata)
    );

    // 10-unit clock
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Start an access from IDLE at a falling edge. Ack on BUSY cycle ack_at
    // (0 = never ack), then check the DONE cycle and the return to IDLE.
    task automatic run_access(input string       name,
                              input logic        rd,
                              input logic        wr,
                              input logic        m2r,
                              input logic [1:0]  size,
                              input logic        uns,
                              input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input int          ack_at,
                              input logic [31:0] rdata,
                              input logic [31:0] exp_wb,
                              input logic [3:0]  exp_be,
                              input logic [31:0] exp_bwd,
                              input logic        exp_we,
                              input logic        exp_err);
        int   n;
        int   exp_n;
        logic done;
        logic [31:0] exp_addr;
        exp_addr   = {addr[31:2], 2'b00};
        exp_n      = (ack_at != 0) ? ack_at : TIMEOUT;
        i_memRead  = rd;
        i_memWrite = wr;
        i_memToReg = m2r;
        i_size     = size;
        i_unsigned = uns;
        i_addr     = addr;
        i_wdata    = wdata;
        sb_q.push_back(exp_wb);
        #1;
        check({name, "_idle_stall"}, {31'd0, o_stall}, 32'd1);
        check({name, "_idle_alignerr"}, {31'd0, o_alignErr}, 32'd0);
        @(negedge i_clk);
        check({name, "_req"}, {31'd0, o_bus_req}, 32'd1);
        check({name, "_we"}, {31'd0, o_bus_we}, {31'd0, exp_we});
        check({name, "_bus_addr"}, o_bus_addr, exp_addr);
        check({name, "_be"}, {28'd0, o_bus_be}, {28'd0, exp_be});
        check({name, "_bus_wdata"}, o_bus_wdata, exp_bwd);
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            if (ack_at != 0 && n + 1 == ack_at) begin
                i_bus_ack   = 1'b1;
                i_bus_rdata = rdata;
            end
            @(negedge i_clk);
            i_bus_ack   = 1'b0;
            i_bus_rdata = 32'h5A5A_5A5A;
            n++;
            if (!o_stall) done = 1'b1;
        end
        check({name, "_done_reached"}, {31'd0, done}, 32'd1);
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
        check({name, "_done_req"}, {31'd0, o_bus_req}, 32'd0);
        check({name, "_done_buserr"}, {31'd0, o_busErr}, {31'd0, exp_err});
        if (sb_q.size() > 0) begin
            check({name, "_wbdata"}, o_wbData, sb_q.pop_front());
        end else begin
            check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
        end
        i_memRead  = 1'b0;
        i_memWrite = 1'b0;
        @(negedge i_clk);
        check({name, "_idle_buserr"}, {31'd0, o_busErr}, 32'd0);
        check({name, "_idle_req"}, {31'd0, o_bus_req}, 32'd0);
        check({name, "_idle_stall_low"}, {31'd0, o_stall}, 32'd0);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_addr      = 32'h0000_0055;
        i_wdata     = 32'd0;
        i_memRead   = 1'b0;
        i_memWrite  = 1'b0;
        i_memToReg  = 1'b0;
        i_size      = 2'b10;
        i_unsigned  = 1'b0;
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'd0;

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_req", {31'd0, o_bus_req}, 32'd0);
        check("rst_we", {31'd0, o_bus_we}, 32'd0);
        check("rst_addr", o_bus_addr, 32'd0);
        check("rst_be", {28'd0, o_bus_be}, 32'd0);
        check("rst_wdata", o_bus_wdata, 32'd0);
        check("rst_buserr", {31'd0, o_busErr}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_wb_pass", o_wbData, 32'h0000_0055);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Non-memory instruction: ALU result passes straight through.
        i_addr = 32'h1357_9BDF;
        #1;
        check("alu_wb_pass", o_wbData, 32'h1357_9BDF);
        check("alu_no_stall", {31'd0, o_stall}, 32'd0);
        @(negedge i_clk);

        // lw, ack on the 2nd BUSY cycle
        run_access("lw_100", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'd0,
                   2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'd0, 1'b0, 1'b0);
        // lb / lbu from lane 3
        run_access("lb_103", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'd0,
                   1, 32'h80FF_FF7F, 32'hFFFF_FF80, 4'b1000, 32'd0, 1'b0, 1'b0);
        run_access("lbu_103", 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0103, 32'd0,
                   1, 32'h80FF_FF7F, 32'h0000_0080, 4'b1000, 32'd0, 1'b0, 1'b0);
        // lh from the upper half with sign extension; lhu from the lower half
        run_access("lh_002", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'd0,
                   3, 32'h8001_1234, 32'hFFFF_8001, 4'b1100, 32'd0, 1'b0, 1'b0);
        run_access("lhu_000", 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0000, 32'd0,
                   1, 32'h1234_F00D, 32'h0000_F00D, 4'b0011, 32'd0, 1'b0, 1'b0);
        // sh: upper lanes, replicated data, write-back is the address
        run_access("sh_102", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD,
                   1, 32'd0, 32'h0000_0102, 4'b1100, 32'hABCD_ABCD, 1'b1, 1'b0);
        // sb to lane 1
        run_access("sb_041", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0041, 32'h0000_00A5,
                   2, 32'd0, 32'h0000_0041, 4'b0010, 32'hA5A5_A5A5, 1'b1, 1'b0);
        // Read and write both set: read wins
        run_access("rdwr_040", 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1122_3344,
                   1, 32'h0000_0099, 32'h0000_0099, 4'b1111, 32'h1122_3344, 1'b0, 1'b0);

        // Misaligned word load: flag only, no stall, no request
        i_memRead  = 1'b1;
        i_memToReg = 1'b1;
        i_size     = 2'b10;
        i_addr     = 32'h0000_0102;
        #1;
        check("mis_lw_alignerr", {31'd0, o_alignErr}, 32'd1);
        check("mis_lw_stall", {31'd0, o_stall}, 32'd0);
        check("mis_lw_wb", o_wbData, 32'd0);
        @(negedge i_clk);
        check("mis_lw_req", {31'd0, o_bus_req}, 32'd0);
        check("mis_lw_alignerr2", {31'd0, o_alignErr}, 32'd1);
        // Misaligned halfword store is suppressed
        i_memRead  = 1'b0;
        i_memWrite = 1'b1;
        i_size     = 2'b01;
        i_addr     = 32'h0000_0101;
        #1;
        check("mis_sh_alignerr", {31'd0, o_alignErr}, 32'd1);
        @(negedge i_clk);
        check("mis_sh_req", {31'd0, o_bus_req}, 32'd0);
        i_memWrite = 1'b0;
        #1;
        check("mis_clear_alignerr", {31'd0, o_alignErr}, 32'd0);
        @(negedge i_clk);

        // Timeouts: a store, then a load that writes back zero
        run_access("sw_timeout", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'hCAFE_0001,
                   0, 32'd0, 32'h0000_0080, 4'b1111, 32'hCAFE_0001, 1'b1, 1'b1);
        run_access("lw_timeout", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'd0,
                   0, 32'd0, 32'h0000_0000, 4'b1111, 32'd0, 1'b0, 1'b1);
        // An ack in the final permitted cycle still counts as success.
        run_access("lw_ack_last", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'd0,
                   TIMEOUT, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 32'd0, 1'b0, 1'b0);

        // Asynchronous reset while BUSY
        i_memRead  = 1'b1;
        i_memToReg = 1'b1;
        i_size     = 2'b10;
        i_addr     = 32'h0000_0200;
        @(negedge i_clk);
        check("arst_busy_req", {31'd0, o_bus_req}, 32'd1);
        i_rst = 1'b1;
        #1;
        check("arst_req_drop", {31'd0, o_bus_req}, 32'd0);
        check("arst_be_clear", {28'd0, o_bus_be}, 32'd0);
        i_memRead = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("arst_idle_req", {31'd0, o_bus_req}, 32'd0);
        run_access("lw_after_rst", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'd0,
                   1, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111, 32'd0, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
